// File: rtl/tap_mac_filter.sv
// Four-tap weighted sum over captured shift-register taps. One shared multiplier
// walks the taps over four cycles; the result is rounded, saturated and strobed out.
module tap_mac_filter #(
  parameter int                       COEF_W = 8,
  parameter logic signed [COEF_W-1:0] C0     = 1,
  parameter logic signed [COEF_W-1:0] C1     = 2,
  parameter logic signed [COEF_W-1:0] C2     = 2,
  parameter logic signed [COEF_W-1:0] C3     = 1,
  parameter int                       SHIFT  = 0,
  parameter int                       OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       tap0,
  input  logic [7:0]       tap1,
  input  logic [7:0]       tap2,
  input  logic [7:0]       tap3,
  input  logic             clr_ovr,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             overrun
);

  localparam int PROD_W = 9 + COEF_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam int RW     = ACC_W + 1;  // one spare bit so the rounding add cannot wrap

  localparam logic signed [RW-1:0] RND    = RW'((64'sd1 <<< SHIFT) >>> 1);
  localparam logic signed [RW-1:0] SAT_HI = RW'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [RW-1:0] SAT_LO = RW'(-(64'sd1 <<< (OUT_W-1)));

  typedef enum logic {IDLE, MAC} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                idx_q;
  logic [3:0][7:0]           tap_q;
  logic signed [ACC_W-1:0]   acc_q, acc_sum;
  logic signed [8:0]         tap_s;
  logic signed [COEF_W-1:0]  coef;
  logic signed [PROD_W-1:0]  prod;
  logic signed [RW-1:0]      rnd, shr;
  logic signed [OUT_W-1:0]   sat;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)     state_d = MAC;
      MAC:     if (idx_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == MAC);

  // Shared multiplier: unsigned tap zero-extended to a positive signed operand
  always_comb begin
    tap_s = $signed({1'b0, tap_q[idx_q]});
    case (idx_q)
      2'd0:    coef = C0;
      2'd1:    coef = C1;
      2'd2:    coef = C2;
      default: coef = C3;
    endcase
    prod    = PROD_W'(tap_s) * PROD_W'(coef);
    acc_sum = acc_q + ACC_W'(prod);
    rnd     = RW'(acc_sum) + RND;
    shr     = rnd >>> SHIFT;
    if (shr > SAT_HI)      sat = SAT_HI[OUT_W-1:0];
    else if (shr < SAT_LO) sat = SAT_LO[OUT_W-1:0];
    else                   sat = shr[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          tap_q <= {tap3, tap2, tap1, tap0};
          acc_q <= '0;
          idx_q <= '0;
        end
        MAC: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            out_valid <= 1'b1;
            out_data  <= sat;
          end
        end
        default: ;
      endcase
      // A new overrun beats a simultaneous clear
      if (in_valid && busy) overrun <= 1'b1;
      else if (clr_ovr)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_mac_filter.sv
// Randomized bench for tap_mac_filter: three parameterizations share one stimulus
// stream and are checked against an arithmetic reference of the weighted sum.
module tb_tap_mac_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, clr_ovr;
  logic [7:0] tap0, tap1, tap2, tap3;

  logic        busy_d, ov_d, ovr_d;
  logic [15:0] od_d;
  logic        busy_s, ov_s, ovr_s;
  logic [7:0]  od_s;
  logic        busy_a, ov_a, ovr_a;
  logic [9:0]  od_a;

  int n_cmp = 0;
  int n_err = 0;
  int et[4];

  always #5 clk = ~clk;

  tap_mac_filter u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3), .clr_ovr(clr_ovr),
    .busy(busy_d), .out_valid(ov_d), .out_data(od_d), .overrun(ovr_d));

  tap_mac_filter #(.OUT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3), .clr_ovr(clr_ovr),
    .busy(busy_s), .out_valid(ov_s), .out_data(od_s), .overrun(ovr_s));

  tap_mac_filter #(.C0(-3), .C1(7), .C2(-6), .C3(2), .SHIFT(2), .OUT_W(10)) u_alt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3), .clr_ovr(clr_ovr),
    .busy(busy_a), .out_valid(ov_a), .out_data(od_a), .overrun(ovr_a));

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int ref_out(input int t0, t1, t2, t3, c0, c1, c2, c3, sh, ow);
    int acc, hi, lo;
    acc = t0*c0 + t1*c1 + t2*c2 + t3*c3;
    if (sh > 0) acc = acc + (1 << (sh-1));
    acc = acc >>> sh;
    hi  = (1 << (ow-1)) - 1;
    lo  = -(1 << (ow-1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    tap0 = 8'($urandom); tap1 = 8'($urandom); tap2 = 8'($urandom); tap3 = 8'($urandom);
  endtask

  task automatic start(input int t0, t1, t2, t3);
    in_valid = 1'b1;
    tap0 = 8'(t0); tap1 = 8'(t1); tap2 = 8'(t2); tap3 = 8'(t3);
    et[0] = t0; et[1] = t1; et[2] = t2; et[3] = t3;
    tick();
    in_valid = 1'b0;
    chk("busy_after_capture", int'(busy_d), 1);
  endtask

  // Waits for the result of the last captured sample; 'done' ticks already elapsed
  task automatic wait_res(input string tag, input int done);
    int n;
    n = done;
    while (!ov_d && n < 10) begin
      scramble();
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_vld_sat"}, int'(ov_s), 1);
    chk({tag, "_vld_alt"}, int'(ov_a), 1);
    chk({tag, "_def"}, int'($signed(od_d)), ref_out(et[0], et[1], et[2], et[3], 1, 2, 2, 1, 0, 16));
    chk({tag, "_sat"}, int'($signed(od_s)), ref_out(et[0], et[1], et[2], et[3], 1, 2, 2, 1, 0, 8));
    chk({tag, "_alt"}, int'($signed(od_a)), ref_out(et[0], et[1], et[2], et[3], -3, 7, -6, 2, 2, 10));
  endtask

  task automatic after_res(input string tag);
    int held;
    held = int'($signed(od_a));
    tick();
    chk({tag, "_vld_drop"}, int'(ov_d), 0);
    chk({tag, "_hold"}, int'($signed(od_a)), held);
  endtask

  initial begin
    int n, seen;
    rst_n = 1'b0; in_valid = 1'b0; clr_ovr = 1'b0;
    tap0 = '0; tap1 = '0; tap2 = '0; tap3 = '0;
    #12;
    chk("rst_busy", int'(busy_d), 0);
    chk("rst_vld", int'(ov_d), 0);
    chk("rst_data", int'(od_d), 0);
    chk("rst_ovr", int'(ovr_d), 0);
    rst_n = 1'b1;
    tick();

    start(10, 20, 30, 40);
    wait_res("basic", 0);
    chk("basic_const", int'($signed(od_d)), 150);
    after_res("basic");

    start(255, 255, 255, 255);
    wait_res("max", 0);
    chk("max_const", int'($signed(od_d)), 1530);
    chk("max_sat8", int'($signed(od_s)), 127);
    after_res("max");

    start(1, 1, 0, 0);
    wait_res("round", 0);
    chk("round_alt", int'($signed(od_a)), 1);  // -3+7=4, (4+2)>>>2 = 1
    after_res("round");

    // Overrun: second strobe two cycles after the first is dropped
    start(3, 5, 7, 9);
    tick();
    in_valid = 1'b1; scramble();
    tick();
    in_valid = 1'b0;
    chk("ovr_set", int'(ovr_d), 1);
    wait_res("ovr_first", 2);
    chk("ovr_sticky", int'(ovr_d), 1);
    tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", int'(ovr_d), 0);

    // Set beats clear in the same cycle
    start(100, 0, 50, 200);
    in_valid = 1'b1; clr_ovr = 1'b1;
    tick();
    in_valid = 1'b0; clr_ovr = 1'b0;
    chk("ovr_set_wins", int'(ovr_d), 1);
    wait_res("ovr_sw", 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr2", int'(ovr_d), 0);

    // Back-to-back: new strobe in the out_valid cycle is accepted
    start(11, 22, 33, 44);
    wait_res("b2b_a", 0);
    start(200, 150, 100, 50);
    chk("b2b_no_ovr", int'(ovr_d), 0);
    wait_res("b2b_b", 0);
    chk("b2b_no_ovr2", int'(ovr_d), 0);
    after_res("b2b");

    // Reset mid-computation
    start(9, 8, 7, 6);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_d), 0);
    chk("mid_rst_vld", int'(ov_d), 0);
    chk("mid_rst_data", int'(od_d), 0);
    chk("mid_rst_data_alt", int'(od_a), 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov_d) seen++;
    end
    chk("mid_rst_no_vld", seen, 0);
    start(9, 8, 7, 6);
    wait_res("post_rst", 0);
    after_res("post_rst");

    // Random samples with random gaps, including edge values
    for (int k = 0; k < 30; k++) begin
      n = int'($urandom_range(0, 3));
      for (int g = 0; g < n; g++) tick();
      case (k % 10)
        0:       start(0, 0, 0, 0);
        1:       start(255, 0, 0, 255);
        2:       start(0, 255, 255, 0);
        default: start(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      endcase
      wait_res("rand", 0);
      if (k % 3 == 0) after_res("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
